// File: rtl/prog_mem_loader.sv
// Byte-stream loader: frames of little-endian words into instruction/data memory, plus CPU reset control.
// Optional trailing frame checksum when LOADER_CKSUM_EN is defined.
module prog_mem_loader #(
    parameter int IADDR_W   = 8,
    parameter int DADDR_W   = 8,
    parameter int INST_SIZE = 32,
    parameter int WORD      = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic                 imem_we,
    output logic [IADDR_W-1:0]   imem_addr,
    output logic [INST_SIZE-1:0] imem_wdata,
    output logic                 dmem_we,
    output logic [DADDR_W-1:0]   dmem_addr,
    output logic [WORD-1:0]      dmem_wdata,
    output logic                 cpu_rst,
    output logic                 busy,
    output logic                 err,
    output logic [15:0]          load_cnt
);
    // Each state is named after the last header byte consumed.
    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_TGT_OK  = 4'd1;
    localparam logic [3:0] S_CNT_HI  = 4'd2;
    localparam logic [3:0] S_CNT_LO  = 4'd3;
    localparam logic [3:0] S_ADR_HI  = 4'd4;
    localparam logic [3:0] S_PAYLOAD = 4'd5;
    localparam logic [3:0] S_CKSUM   = 4'd6;
    localparam logic [3:0] S_RUN     = 4'd7;
    localparam logic [3:0] S_ERR     = 4'd8;

`ifdef LOADER_CKSUM_EN
    localparam logic [3:0] S_END = S_CKSUM;
    logic [7:0] csum;
`else
    localparam logic [3:0] S_END = S_IDLE;
`endif

    localparam logic [2:0] I_LAST = 3'(INST_SIZE/8 - 1);
    localparam logic [2:0] D_LAST = 3'(WORD/8 - 1);

    logic [3:0]      state;
    logic            tgt_d;
    logic [15:0]     cnt;
    logic [15:0]     waddr;
    logic [2:0]      bidx;
    logic [WORD-9:0] wbuf;
    logic            accept;
    logic            word_done;

    assign in_ready  = 1'b1;
    assign accept    = in_valid && in_ready;
    assign word_done = (bidx == (tgt_d ? D_LAST : I_LAST));
    assign err       = (state == S_ERR);
    assign busy      = ((state >= S_TGT_OK) && (state <= S_CKSUM)) || imem_we || dmem_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            tgt_d      <= 1'b0;
            cnt        <= '0;
            waddr      <= '0;
            bidx       <= '0;
            wbuf       <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            cpu_rst    <= 1'b1;
            load_cnt   <= '0;
`ifdef LOADER_CKSUM_EN
            csum       <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            dmem_we <= 1'b0;
            if (accept) begin
`ifdef LOADER_CKSUM_EN
                csum <= (state == S_IDLE) ? in_data : (csum ^ in_data);
`endif
                case (state)
                    S_IDLE: begin
                        case (in_data)
                            8'h49: begin tgt_d <= 1'b0; state <= S_TGT_OK; end
                            8'h44: begin tgt_d <= 1'b1; state <= S_TGT_OK; end
                            8'h47: begin cpu_rst <= 1'b0; state <= S_RUN; end
                            default: state <= S_ERR;
                        endcase
                    end
                    S_TGT_OK: begin cnt[15:8]   <= in_data; state <= S_CNT_HI; end
                    S_CNT_HI: begin cnt[7:0]    <= in_data; state <= S_CNT_LO; end
                    S_CNT_LO: begin waddr[15:8] <= in_data; state <= S_ADR_HI; end
                    S_ADR_HI: begin
                        waddr[7:0] <= in_data;
                        bidx       <= '0;
                        state      <= (cnt == 16'd0) ? S_END : S_PAYLOAD;
                    end
                    S_PAYLOAD: begin
                        wbuf <= {in_data, wbuf[WORD-9:8]};
                        bidx <= bidx + 3'd1;
                        if (word_done) begin
                            // Bytes arrive LSB first, so the final byte is the top of the word.
                            if (tgt_d) begin
                                dmem_we    <= 1'b1;
                                dmem_addr  <= waddr[DADDR_W-1:0];
                                dmem_wdata <= {in_data, wbuf};
                            end else begin
                                imem_we    <= 1'b1;
                                imem_addr  <= waddr[IADDR_W-1:0];
                                imem_wdata <= {in_data, wbuf[WORD-9 -: INST_SIZE-8]};
                            end
                            if (load_cnt != 16'hFFFF)
                                load_cnt <= load_cnt + 16'd1;
                            bidx  <= '0;
                            waddr <= waddr + 16'd1;
                            cnt   <= cnt - 16'd1;
                            if (cnt == 16'd1)
                                state <= S_END;
                        end
                    end
`ifdef LOADER_CKSUM_EN
                    S_CKSUM: state <= (in_data == csum) ? S_IDLE : S_ERR;
`endif
                    S_RUN: begin
                        if (in_data == 8'h48) begin
                            cpu_rst <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            state <= S_ERR;
                        end
                    end
                    default: state <= S_ERR;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_prog_mem_loader.sv
// Scoreboard bench for prog_mem_loader: expected writes queued by the driver, checked by a write monitor.
module tb_prog_mem_loader;
    logic        tb_clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we, dmem_we;
    logic [7:0]  imem_addr, dmem_addr;
    logic [31:0] imem_wdata;
    logic [63:0] dmem_wdata;
    logic        cpu_rst, busy, err;
    logic [15:0] load_cnt;

    typedef struct {
        bit          is_d;
        logic [7:0]  addr;
        logic [63:0] data;
    } wr_t;

    wr_t  exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    logic [7:0] fq[$];

    prog_mem_loader dut (
        .clk(tb_clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .cpu_rst(cpu_rst), .busy(busy), .err(err), .load_cnt(load_cnt)
    );

    always #5 tb_clk = ~tb_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the scoreboard.
    always @(negedge tb_clk) begin
        if (imem_we || dmem_we) begin
            n_vec++;
            if (imem_we && dmem_we) begin
                n_bad++;
                $display("FAIL dual_we: imem_we and dmem_we both high");
            end else if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: d=%0b addr=%0h", dmem_we,
                         dmem_we ? dmem_addr : imem_addr);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (e.is_d != dmem_we ||
                    (dmem_we && (dmem_addr !== e.addr || dmem_wdata !== e.data)) ||
                    (imem_we && (imem_addr !== e.addr || imem_wdata !== e.data[31:0]))) begin
                    n_bad++;
                    $display("FAIL write: got d=%0b addr=%0h data=%0h expected d=%0b addr=%0h data=%0h",
                             dmem_we, dmem_we ? dmem_addr : imem_addr,
                             dmem_we ? dmem_wdata : {32'h0, imem_wdata},
                             e.is_d, e.addr, e.data);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        do begin
            @(posedge tb_clk);
            t++;
        end while (!in_ready && t < 100);
        if (t >= 100) begin
            n_vec++; n_bad++;
            $display("FAIL ready_timeout: in_ready low for %0d cycles", t);
        end
        #1 in_valid = 1'b0;
        repeat (gap) @(posedge tb_clk);
        if (gap > 0) #1;
    endtask

    // Sends the frame in fq; appends the XOR checksum when the option is built in.
    task automatic send_frame(input int gap);
        logic [7:0] x;
        x = 8'h00;
        foreach (fq[i]) begin
            x ^= fq[i];
            send_byte(fq[i], gap);
        end
`ifdef LOADER_CKSUM_EN
        send_byte(x, gap);
`endif
        fq.delete();
    endtask

    task automatic push_wr(input bit d, input logic [7:0] a, input logic [63:0] v);
        wr_t w;
        w.is_d = d; w.addr = a; w.data = v;
        exp_q.push_back(w);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_we"}, {imem_we, dmem_we}, 0);
        chk({tag, "_addr"}, {imem_addr, dmem_addr}, 0);
        chk({tag, "_wdata"}, {imem_wdata, dmem_wdata[31:0]}, 0);
        chk({tag, "_dwdata_hi"}, dmem_wdata[63:32], 0);
        chk({tag, "_cpu_rst"}, cpu_rst, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_load_cnt"}, load_cnt, 0);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        repeat (2) @(posedge tb_clk);
        #1;
    endtask

    initial begin
        in_valid = 1'b0;
        in_data  = 8'h00;
        do_reset();
        check_reset_state("rst0");
        rst = 1'b0;
        @(posedge tb_clk); #1;

        // imem frame, two words
        push_wr(0, 8'h10, 64'hF8400009);
        push_wr(0, 8'h11, 64'h8B1F03E9);
        fq = '{8'h49, 8'h00, 8'h02, 8'h00, 8'h10};
        send_byte(fq[0], 0);
        chk("busy_after_tgt", busy, 1);
        fq.pop_front();
        begin
            logic [7:0] rest[$];
            rest = '{8'h09, 8'h00, 8'h40, 8'hF8, 8'hE9, 8'h03, 8'h1F, 8'h8B};
            foreach (rest[i]) fq.push_back(rest[i]);
        end
`ifdef LOADER_CKSUM_EN
        // TGT already sent by hand; send rest, then checksum over the whole frame
        begin
            logic [7:0] x;
            x = 8'h49;
            foreach (fq[i]) begin x ^= fq[i]; send_byte(fq[i], 0); end
            fq.delete();
            send_byte(x, 0);
        end
`else
        send_frame(0);
`endif
        repeat (2) @(posedge tb_clk); #1;
        chk("t1_load_cnt", load_cnt, 2);
        chk("t1_cpu_rst", cpu_rst, 1);
        chk("t1_busy_end", busy, 0);

        // dmem single word, then GO and HALT
        push_wr(1, 8'h03, 64'h27);
        fq = '{8'h44, 8'h00, 8'h01, 8'h00, 8'h03, 8'h27, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(0);
        send_byte(8'h47, 0);
        chk("go_cpu_rst", cpu_rst, 0);
        send_byte(8'h48, 0);
        chk("halt_cpu_rst", cpu_rst, 1);
        chk("t2_load_cnt", load_cnt, 3);

        // dmem address wrap FF -> 00
        push_wr(1, 8'hFF, 64'h1817161514131211);
        push_wr(1, 8'h00, 64'h2827262524232221);
        fq = '{8'h44, 8'h00, 8'h02, 8'h00, 8'hFF,
               8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18,
               8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
        send_frame(0);
        repeat (2) @(posedge tb_clk); #1;
        chk("t3_load_cnt", load_cnt, 5);

        // gapped in_valid, one byte every 3 cycles
        push_wr(0, 8'h20, 64'hDDCCBBAA);
        fq = '{8'h49, 8'h00, 8'h01, 8'h00, 8'h20, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_frame(2);
        chk("t4_load_cnt", load_cnt, 6);
        chk("t4_err", err, 0);

        // reset mid-frame after two payload bytes: no write
        fq = '{8'h49, 8'h00, 8'h01, 8'h00, 8'h30, 8'h01, 8'h02};
        foreach (fq[i]) send_byte(fq[i], 0);
        fq.delete();
        do_reset();
        check_reset_state("midrst");
        rst = 1'b0;
        repeat (3) @(posedge tb_clk); #1;
        chk("midrst_we_idle", {imem_we, dmem_we}, 0);

`ifdef LOADER_CKSUM_EN
        fq = '{8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
        foreach (fq[i]) send_byte(fq[i], 0);
        fq.delete();
        send_byte(8'h44, 0);
        chk("cksum_ok_err", err, 0);
        chk("cksum_ok_busy", busy, 0);
        fq = '{8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
        foreach (fq[i]) send_byte(fq[i], 0);
        fq.delete();
        send_byte(8'h00, 0);
        chk("cksum_bad_err", err, 1);
        do_reset();
        rst = 1'b0;
`endif

        // bad byte in IDLE: sticky err, G refused, no writes
        send_byte(8'h55, 0);
        chk("bad_err", err, 1);
        send_byte(8'h47, 0);
        chk("bad_go_cpu_rst", cpu_rst, 1);
        fq = '{8'h49, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(0);
        repeat (2) @(posedge tb_clk); #1;
        chk("bad_err_sticky", err, 1);
        chk("bad_load_cnt", load_cnt, 0);
        chk("bad_in_ready", in_ready, 1);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
